// File: rtl/dmem_ctrl_pkg.sv
// Shared encodings for the data-memory responder: funct3 access codes,
// FSM states and the data width.
package dmem_ctrl_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_ctrl_if.sv
// Core-side memory bus: decoder strobes, address/data in, load result,
// stall/done/err back to the core.
interface dmem_ctrl_if;
    import dmem_ctrl_pkg::*;

    logic                  MemRead;
    logic                  MemWrite;
    logic [2:0]            funct3;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  stall;
    logic                  done;
    logic                  err;

    modport master (
        output MemRead, MemWrite, funct3, addr, wdata,
        input  rdata, stall, done, err
    );

    modport slave (
        input  MemRead, MemWrite, funct3, addr, wdata,
        output rdata, stall, done, err
    );

endinterface

// File: rtl/dmem_ctrl_align.sv
// dmem_align: combinational lane select/extension for loads and byte-enable
// generation plus data replication for stores; also flags misaligned accesses.
module dmem_align
    import dmem_ctrl_pkg::*;
(
    input  logic                  i_is_store,
    input  logic [2:0]            i_funct3,
    input  logic [1:0]            i_addr_lo,
    input  logic [DATA_WIDTH-1:0] i_rword,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic [3:0]            o_be,
    output logic [DATA_WIDTH-1:0] o_wdata,
    output logic                  o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Halfwords select on addr[1] only, so a misaligned halfword still lands in a lane.
    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

    always_comb begin
        o_rdata    = i_rword;
        o_be       = 4'b1111;
        o_wdata    = i_wdata;
        o_misalign = 1'b0;
        if (i_is_store) begin
            case (i_funct3)
                FUNCT3_SB: begin
                    o_be    = 4'b0001 << i_addr_lo;
                    o_wdata = {4{i_wdata[7:0]}};
                end
                FUNCT3_SH: begin
                    o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                    o_wdata    = {2{i_wdata[15:0]}};
                    o_misalign = i_addr_lo[0];
                end
                default: o_misalign = |i_addr_lo;
            endcase
        end else begin
            case (i_funct3)
                FUNCT3_LB:  o_rdata = {{24{w_byte[7]}}, w_byte};
                FUNCT3_LBU: o_rdata = {24'd0, w_byte};
                FUNCT3_LH: begin
                    o_rdata    = {{16{w_half[15]}}, w_half};
                    o_misalign = i_addr_lo[0];
                end
                FUNCT3_LHU: begin
                    o_rdata    = {16'd0, w_half};
                    o_misalign = i_addr_lo[0];
                end
                default: o_misalign = |i_addr_lo;
            endcase
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory responder: IDLE/BUSY/DONE FSM, latency counter and word RAM.
// Optional misaligned-access trap enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_ctrl_if.slave     bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    dmem_state_e r_state, w_next_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [2:0]            r_funct3;
    logic                  r_is_store;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_done;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_req;
    logic                  w_accept;
    logic                  w_fire;
    logic                  w_trap;
    logic [IDX_W-1:0]      w_idx;
    logic [DATA_WIDTH-1:0] w_rword;
    logic [DATA_WIDTH-1:0] w_ld_data;
    logic [DATA_WIDTH-1:0] w_st_data;
    logic [3:0]            w_be;
    logic                  w_misalign;
    logic                  w_unused_addr;

    assign w_req         = bus.MemRead | bus.MemWrite;
    assign w_idx         = r_addr[IDX_W+1:2];
    assign w_unused_addr = ^r_addr[DATA_WIDTH-1:IDX_W+2];
    assign w_rword       = r_mem[w_idx];
    assign w_trap        = TRAP_EN & w_misalign;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_fire       = 1'b0;
        bus.stall    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.stall = w_req;
                if (w_req) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                bus.stall = 1'b1;
                if (r_cnt == '0) begin
                    w_fire       = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_rdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_fire;
            if (w_accept)
                r_cnt <= CNT_W'(LATENCY - 1);
            else if (r_state == ST_BUSY && r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
            if (w_fire && !r_is_store && !w_trap)
                r_rdata <= w_ld_data;
        end
    end

    // Simultaneous read+write is recorded as a store so the load path stays untouched.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_addr     <= bus.addr;
            r_wdata    <= bus.wdata;
            r_funct3   <= bus.funct3;
            r_is_store <= bus.MemWrite;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && w_fire && r_is_store && !w_trap) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b])
                    r_mem[w_idx][8*b +: 8] <= w_st_data[8*b +: 8];
            end
        end
    end

    dmem_align u_align (
        .i_is_store (r_is_store),
        .i_funct3   (r_funct3),
        .i_addr_lo  (r_addr[1:0]),
        .i_rword    (w_rword),
        .i_wdata    (r_wdata),
        .o_rdata    (w_ld_data),
        .o_be       (w_be),
        .o_wdata    (w_st_data),
        .o_misalign (w_misalign)
    );

`ifdef DMEM_MISALIGN_TRAP_EN
    logic r_err;
    always_ff @(posedge clk) begin
        if (!rst_n) r_err <= 1'b0;
        else        r_err <= w_fire & w_trap;
    end
    assign bus.err = r_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.rdata = r_rdata;
    assign bus.done  = r_done;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed cases plus random loads/stores scored against
// a byte-level memory model.
module tb_dmem_ctrl;

    localparam int DEPTH   = 1024;
    localparam int LATENCY = 2;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rdata;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: size/offset from funct3 and address, then byte-wise update or extract.
    task automatic model_access(input logic wr, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic exp_err);
        int unsigned size, off, idx;
        logic [31:0] w, v, mask;
        if (wr) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
        else    size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
        exp_err = TRAP && ((a % size) != 0);
        if (exp_err) return;
        idx = (a / 4) % DEPTH;
        off = (size == 1) ? (a % 4) : (size == 2) ? ((a % 4) / 2) * 2 : 0;
        if (wr) begin
            w = m_mem[idx];
            for (int k = 0; k < int'(size); k++)
                w[8*(off+k) +: 8] = wd[8*k +: 8];
            m_mem[idx] = w;
        end else begin
            v = m_mem[idx] >> (8 * off);
            if (size < 4) begin
                mask = 32'((64'd1 << (8 * size)) - 1);
                v = v & mask;
                if ((f3 == 3'd0 || f3 == 3'd1) && v[8*size-1]) v = v | ~mask;
            end
            m_rdata = v;
        end
    endtask

    // Entered just after a rising edge; leaves just after the edge that ends DONE.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int  stalls = 0;
        bit  got = 0;
        logic st_done = 1'b1;
        logic exp_err;
        model_access(wr, f3, a, wd, exp_err);
        bus.MemRead  = rd;
        bus.MemWrite = wr;
        bus.funct3   = f3;
        bus.addr     = a;
        bus.wdata    = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (bus.done) begin
                got = 1;
                st_done = bus.stall;
            end else if (bus.stall) begin
                stalls++;
            end
        end
        chk("done_seen", 32'(got), 32'd1);
        chk("stall_cycles", stalls, LATENCY + 1);
        chk("stall_in_done", 32'(st_done), 32'd0);
        chk("rdata", bus.rdata, m_rdata);
        chk("err", 32'(bus.err), 32'(exp_err));
        @(posedge clk);
        #1;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] f3_tab [8];
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'd0;
        m_rdata      = 32'd0;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        bus.funct3   = 3'd0;
        bus.addr     = 32'd0;
        bus.wdata    = 32'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known contents for the words used below and by the random phase.
        for (int i = 0; i < 24; i++) access(1'b0, 1'b1, 3'd2, 32'(4 * i), 32'd0);

        // Abort a store in its first BUSY cycle.
        bus.MemWrite = 1'b1;
        bus.funct3   = 3'd2;
        bus.addr     = 32'h10;
        bus.wdata    = 32'hDEADBEEF;
        @(negedge clk);
        chk("abort_req_stall", 32'(bus.stall), 32'd1);
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        bus.MemWrite = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("abort_stall", 32'(bus.stall), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_rdata", bus.rdata, 32'd0);
        m_rdata = 32'd0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        access(1'b1, 1'b0, 3'd2, 32'h10, 32'd0);
        chk("abort_lw", bus.rdata, 32'd0);

        access(1'b0, 1'b1, 3'd2, 32'h20, 32'h12345678);
        access(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
        chk("lw_20", bus.rdata, 32'h12345678);

        access(1'b0, 1'b1, 3'd2, 32'h40, 32'h80FF7F01);
        access(1'b1, 1'b0, 3'd0, 32'h43, 32'd0);
        chk("lb_43", bus.rdata, 32'hFFFFFF80);
        access(1'b1, 1'b0, 3'd4, 32'h43, 32'd0);
        chk("lbu_43", bus.rdata, 32'h00000080);
        access(1'b1, 1'b0, 3'd1, 32'h40, 32'd0);
        chk("lh_40", bus.rdata, 32'h00007F01);
        access(1'b1, 1'b0, 3'd5, 32'h42, 32'd0);
        chk("lhu_42", bus.rdata, 32'h000080FF);

        access(1'b0, 1'b1, 3'd2, 32'h50, 32'hAAAAAAAA);
        access(1'b0, 1'b1, 3'd0, 32'h51, 32'h00000011);
        access(1'b0, 1'b1, 3'd1, 32'h52, 32'h00002233);
        access(1'b1, 1'b0, 3'd2, 32'h50, 32'd0);
        chk("partial_50", bus.rdata, 32'h223311AA);

        access(1'b0, 1'b1, 3'd2, 32'h1000, 32'hCAFEF00D);
        access(1'b1, 1'b0, 3'd2, 32'h0, 32'd0);
        chk("wrap_0", bus.rdata, 32'hCAFEF00D);

        access(1'b1, 1'b1, 3'd2, 32'h8, 32'd5);
        chk("both_rdata_held", bus.rdata, 32'hCAFEF00D);
        access(1'b1, 1'b0, 3'd2, 32'h8, 32'd0);
        chk("both_written", bus.rdata, 32'd5);

`ifdef DMEM_MISALIGN_TRAP_EN
        access(1'b1, 1'b0, 3'd2, 32'h22, 32'd0);
        chk("trap_lw_rdata", bus.rdata, 32'd5);
        access(1'b0, 1'b1, 3'd2, 32'h21, 32'hFFFFFFFF);
        access(1'b1, 1'b0, 3'd2, 32'h20, 32'd0);
        chk("trap_sw_mem", bus.rdata, 32'h12345678);
`endif

        for (int n = 0; n < 150; n++) begin
            int unsigned r = $urandom_range(0, 9);
            logic [2:0]  f3 = f3_tab[$urandom_range(0, 7)];
            logic [31:0] a  = $urandom & 32'hFFFFF03F;
            logic [31:0] wd = $urandom;
            if (r < 4)      access(1'b1, 1'b0, f3, a, wd);
            else if (r < 8) access(1'b0, 1'b1, f3, a, wd);
            else            access(1'b1, 1'b1, f3, a, wd);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
